// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-pair prefetcher with a DEPTH-entry buffer, branch/flush redirect and stale-response discard.
// Define INST_FETCH_PERF_EN to add the pairs_issued / bubble_cycles performance counters.
module inst_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [0:14] RESET_PC = 15'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [0:14] imem_addr,
  input  logic        imem_rvalid,
  input  logic [0:63] imem_rdata,
  output logic [0:31] first_inst_output,
  output logic [0:31] second_inst_output,
  output logic [0:14] pair_pc,
  output logic        pair_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [0:14] branch_target,
  input  logic        flush
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [0:31] pairs_issued,
  output logic [0:31] bubble_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, FETCH} state_e;
  state_e        state_q;
  logic [0:14]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, restart_pc, live_bytes;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [1:0]    out_q, out_d, disc_q, disc_d;
  logic [3:0]    occ;
  logic [0:63]   data_q [DEPTH];
  logic [0:14]   pc_q [DEPTH];
  logic          redirect, push, pop;
  assign redirect   = branch_taken | flush;
  assign occ        = 4'(count_q) + 4'(out_q);
  assign pair_valid = !reset && count_q != '0;
  assign imem_req   = !reset && state_q == FETCH && !redirect && occ < 4'(DEPTH) && out_q < 2'd2;
  assign imem_addr  = fetch_pc_q;
  assign push       = imem_rvalid && !redirect && disc_q == '0;
  assign pop        = pair_valid && !stall && !redirect;
  assign first_inst_output  = pair_valid ? data_q[rd_q][0:31] : 32'h40200000;
  assign second_inst_output = pair_valid ? data_q[rd_q][32:63] : 32'h00200000;
  assign pair_pc            = pair_valid ? pc_q[rd_q] : (reset ? RESET_PC : resp_pc_q);
  // With an empty buffer the oldest unconsumed pair is the oldest live request still in flight.
  assign live_bytes = {10'b0, out_q - disc_q, 3'b0};
  assign restart_pc = branch_taken ? branch_target : (count_q != '0 ? pc_q[rd_q] : fetch_pc_q - live_bytes);
  assign fetch_pc_d = redirect ? restart_pc : fetch_pc_q + (imem_req ? 15'd8 : 15'd0);
  assign resp_pc_d  = redirect ? restart_pc : resp_pc_q + (push ? 15'd8 : 15'd0);
  assign out_d      = out_q + 2'(imem_req) - 2'(imem_rvalid);
  // Every request still in flight after a redirect belongs to the abandoned stream.
  assign disc_d     = redirect ? out_q - 2'(imem_rvalid) : disc_q - 2'(imem_rvalid && disc_q != '0);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= FETCH;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      wr_q       <= redirect ? '0 : wr_q + AW'(push);
      rd_q       <= redirect ? '0 : rd_q + AW'(pop);
      count_q    <= redirect ? '0 : count_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      data_q[wr_q] <= imem_rdata;
      pc_q[wr_q]   <= resp_pc_q;
    end
  end
`ifdef INST_FETCH_PERF_EN
  logic [0:31] pairs_q, bubbles_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      pairs_q   <= '0;
      bubbles_q <= '0;
    end else begin
      pairs_q   <= pairs_q + 32'(pop);
      bubbles_q <= bubbles_q + 32'(!pair_valid && state_q == FETCH);
    end
  end
  assign pairs_issued  = pairs_q;
  assign bubble_cycles = bubbles_q;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized self-checking bench; the reference model tracks the architectural pair stream.
module tb_inst_fetch_unit;
  localparam int DEPTH = 4;
  logic        clock = 0, reset = 1;
  logic        imem_req, imem_rvalid = 0, pair_valid, stall = 0, branch_taken = 0, flush = 0;
  logic [0:14] imem_addr, pair_pc, branch_target = '0;
  logic [0:63] imem_rdata = '0;
  logic [0:31] first_inst_output, second_inst_output;
  logic        req2, rv2 = 0, pv2;
  logic [0:14] addr2, ppc2;
  logic [0:63] rd2 = '0;
  logic [0:31] f2, s2;
`ifdef INST_FETCH_PERF_EN
  logic [0:31] pairs_issued, bubble_cycles, pi2, bc2;
`endif
  always #5 clock = ~clock;

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(15'h0000)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .first_inst_output(first_inst_output), .second_inst_output(second_inst_output),
    .pair_pc(pair_pc), .pair_valid(pair_valid), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush)
`ifdef INST_FETCH_PERF_EN
    , .pairs_issued(pairs_issued), .bubble_cycles(bubble_cycles)
`endif
  );

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(15'h7FF0)) dut2 (
    .clock(clock), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rv2), .imem_rdata(rd2),
    .first_inst_output(f2), .second_inst_output(s2),
    .pair_pc(ppc2), .pair_valid(pv2), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(15'h0000), .flush(1'b0)
`ifdef INST_FETCH_PERF_EN
    , .pairs_issued(pi2), .bubble_cycles(bc2)
`endif
  );

  function automatic logic [0:63] mem_word(input logic [0:14] a);
    return {32'h40800A01 ^ {17'b0, a}, 32'h00200000 ^ {a, 17'b0}};
  endfunction

  // Memory models: in-order, latency 1 or 2, cleared by reset.
  int          lat = 1;
  logic        p_v = 0;
  logic [0:14] p_a = '0;
  always @(posedge clock) begin
    if (reset) begin
      imem_rvalid <= 1'b0;
      p_v         <= 1'b0;
    end else if (lat == 1) begin
      imem_rvalid <= imem_req;
      imem_rdata  <= mem_word(imem_addr);
    end else begin
      imem_rvalid <= p_v;
      imem_rdata  <= mem_word(p_a);
      p_v         <= imem_req;
      p_a         <= imem_addr;
    end
  end
  always @(posedge clock) begin
    rv2 <= !reset && req2;
    rd2 <= mem_word(addr2);
  end

  int          total = 0, bad = 0, nreq = 0, consumed = 0;
  logic [0:14] exp_pc = '0;
  logic        hold = 0;
  logic [0:79] snap = '0;

  // One cycle: drive inputs after negedge, observe, and advance the pair-stream model.
  task automatic step(input logic rst, input logic stl, input logic br, input logic [0:14] tgt, input logic fl);
    logic [0:63] w;
    @(negedge clock);
    reset = rst; stall = stl; branch_taken = br; branch_target = tgt; flush = fl;
    #1;
    if (imem_req) begin
      nreq++;
      total++;
      if (imem_addr[12:14] !== 3'b000) begin
        bad++; $display("FAIL align: imem_addr=%h required low bits 000", imem_addr);
      end
    end
    if (hold && !rst) begin
      total++;
      if ({pair_valid, pair_pc, first_inst_output, second_inst_output} !== snap) begin
        bad++; $display("FAIL stall_stable: got %h required %h", {pair_valid, pair_pc, first_inst_output, second_inst_output}, snap);
      end
    end
    hold = !rst && pair_valid && stl && !br && !fl;
    snap = {pair_valid, pair_pc, first_inst_output, second_inst_output};
    if (rst) exp_pc = 15'h0000;
    else if (br) exp_pc = tgt;
    else if (!fl && pair_valid && !stl) begin
      w = mem_word(exp_pc);
      total++;
      if ({pair_pc, first_inst_output, second_inst_output} !== {exp_pc, w}) begin
        bad++; $display("FAIL consume: got pc=%h %h %h required pc=%h %h", pair_pc, first_inst_output, second_inst_output, exp_pc, w);
      end
      exp_pc += 15'd8;
      consumed++;
    end
  endtask

  task automatic do_reset(input int l);
    lat = l;
    step(1, 1, 0, '0, 0);
    step(1, 1, 0, '0, 0);
  endtask

  task automatic test_reset();
    do_reset(1);
    total++;
    if ({imem_req, pair_valid, first_inst_output, second_inst_output, pair_pc} !== {1'b0, 1'b0, 32'h40200000, 32'h00200000, 15'h0000}) begin
      bad++; $display("FAIL reset_outputs: req=%b valid=%b %h %h pc=%h required 0 0 40200000 00200000 0000",
                      imem_req, pair_valid, first_inst_output, second_inst_output, pair_pc);
    end
  endtask

  task automatic test_first_fetch();
    step(0, 0, 0, '0, 0);
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: req=%b required 0", imem_req); end
    step(0, 0, 0, '0, 0);
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 15'h0000}) begin
      bad++; $display("FAIL first_req: req=%b addr=%h required 1 0000", imem_req, imem_addr);
    end
    step(0, 0, 0, '0, 0);
    total++;
    if (pair_valid !== 1'b0) begin bad++; $display("FAIL early_valid: valid=%b required 0", pair_valid); end
    step(0, 1, 0, '0, 0);
    total++;
    if ({pair_valid, first_inst_output, second_inst_output} !== {1'b1, 32'h40800A01, 32'h00200000}) begin
      bad++; $display("FAIL first_pair: valid=%b %h %h required 1 40800a01 00200000", pair_valid, first_inst_output, second_inst_output);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset(1);
    c0 = consumed;
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 0);
    total++;
    if (consumed - c0 !== 17) begin bad++; $display("FAIL back_to_back: consumed=%0d required 17", consumed - c0); end
  endtask

  task automatic test_stall();
    int c0;
    do_reset(1);
    nreq = 0;
    for (int i = 0; i < 12; i++) step(0, 1, 0, '0, 0);
    total++;
    if (nreq !== DEPTH) begin bad++; $display("FAIL stall_fill: requests=%0d required %0d", nreq, DEPTH); end
    total++;
    if ({imem_req, pair_valid, pair_pc} !== {1'b0, 1'b1, 15'h0000}) begin
      bad++; $display("FAIL stall_full: req=%b valid=%b pc=%h required 0 1 0000", imem_req, pair_valid, pair_pc);
    end
    c0 = consumed;
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, '0, 0);
    total++;
    if (consumed - c0 !== DEPTH) begin bad++; $display("FAIL drain: consumed=%0d required %0d", consumed - c0, DEPTH); end
  endtask

  task automatic test_branch();
    int n = 0;
    do_reset(2);
    while (1) begin
      @(posedge clock); #1;
      if (imem_rvalid && p_v && n >= 3) break;
      if (n > 40) begin bad++; total++; $display("FAIL branch_setup: two in flight not seen, cycles=%0d", n); return; end
      step(0, 0, 0, '0, 0);
      n++;
    end
    step(0, 0, 1, 15'h0100, 0);
    step(0, 1, 0, '0, 0);
    total++;
    if ({pair_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 15'h0100}) begin
      bad++; $display("FAIL branch_refetch: valid=%b req=%b addr=%h required 0 1 0100", pair_valid, imem_req, imem_addr);
    end
    n = 0;
    while (!pair_valid && n < 20) begin step(0, 1, 0, '0, 0); n++; end
    total++;
    if ({pair_valid, pair_pc, first_inst_output} !== {1'b1, 15'h0100, 32'h40800B01}) begin
      bad++; $display("FAIL branch_pair: valid=%b pc=%h first=%h required 1 0100 40800b01", pair_valid, pair_pc, first_inst_output);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0, 0);
  endtask

  task automatic test_flush();
    int n = 0;
    do_reset(1);
    while (1) begin
      @(posedge clock); #1;
      if (pair_valid && pair_pc == 15'h0040) break;
      if (n > 40) begin bad++; total++; $display("FAIL flush_setup: head 0040 not seen, cycles=%0d", n); return; end
      step(0, 0, 0, '0, 0);
      n++;
    end
    step(0, 0, 0, '0, 1);
    step(0, 1, 0, '0, 0);
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 15'h0040}) begin
      bad++; $display("FAIL flush_refetch: req=%b addr=%h required 1 0040", imem_req, imem_addr);
    end
    n = 0;
    while (!pair_valid && n < 20) begin step(0, 1, 0, '0, 0); n++; end
    total++;
    if ({pair_valid, pair_pc} !== {1'b1, 15'h0040}) begin
      bad++; $display("FAIL flush_pair: valid=%b pc=%h required 1 0040", pair_valid, pair_pc);
    end
    for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(0, 1)), 0, '0, 0);
  endtask

  task automatic test_wrap();
    logic [0:14] q[$];
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, '0, 0);
      if (req2) q.push_back(addr2);
    end
    total++;
    if (q.size() < 3) begin
      bad++; $display("FAIL wrap_count: requests=%0d required >=3", q.size());
    end else begin
      total++;
      if ({q[0], q[1], q[2]} !== {15'h7FF0, 15'h7FF8, 15'h0000}) begin
        bad++; $display("FAIL wrap_seq: %h %h %h required 7ff0 7ff8 0000", q[0], q[1], q[2]);
      end
    end
  endtask

  task automatic test_random();
    int c0;
    logic [0:14] tgt;
    for (int r = 0; r < 4; r++) begin
      do_reset(r % 2 + 1);
      c0 = consumed;
      for (int i = 0; i < 250; i++) begin
        tgt = 15'($urandom_range(0, 4095) << 3);
        step(0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3, tgt, $urandom_range(0, 99) < 3);
      end
      total++;
      if (consumed - c0 < 20) begin bad++; $display("FAIL random_progress: consumed=%0d required >=20", consumed - c0); end
    end
  endtask

`ifdef INST_FETCH_PERF_EN
  task automatic test_perf();
    int pops = 0, bub = 0;
    logic s;
    do_reset(1);
    for (int i = 0; i < 40 && pops < 5; i++) begin
      s = (i >= 3 && i < 6);
      step(0, s, 0, '0, 0);
      if (i >= 1 && !pair_valid) bub++;
      if (pair_valid && !s) pops++;
    end
    @(posedge clock); #1;
    total++;
    if (pairs_issued !== 32'd5) begin bad++; $display("FAIL perf_pairs: got %0d required 5", pairs_issued); end
    total++;
    if (bubble_cycles !== 32'(bub)) begin bad++; $display("FAIL perf_bubbles: got %0d required %0d", bubble_cycles, bub); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall();
    test_branch();
    test_flush();
    test_wrap();
    test_random();
`ifdef INST_FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
